// File: rtl/cfg_seq_pkg.sv
// Shared types and helpers for the column frame-strobe sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state enum, column/counter widths, one-hot decode of a frame index.
package cfg_seq_pkg;

  localparam int COL_W = 5;   // column ID width (up to 32 columns)
  localparam int CNT_W = 4;   // phase down-counter width (phases of 1..15 cycles)

  // One-hot decode is done at a fixed maximum width; callers truncate to their strobe width.
  localparam int ONEHOT_MAX_W = 256;
  localparam int ONEHOT_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_e;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot_dec(input logic [ONEHOT_IDX_W-1:0] idx);
    logic [ONEHOT_MAX_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/strobe_onehot_reg.sv
// Registered one-hot decoder: strobe_o[idx_i] is high the cycle after en_i, all bits low otherwise.
// Latency: 1 cycle from en_i/idx_i to strobe_o. Backpressure: none (free-running register).
// Ports: clk, rst_n (sync, active low), en_i, idx_i (frame index), strobe_o (W-bit one-hot or zero).
module strobe_onehot_reg
  import cfg_seq_pkg::*;
#(
  parameter int W  = 20,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [IW-1:0] idx_i,
  output logic [W-1:0]  strobe_o
);

  logic [W-1:0] strobe_d, strobe_q;

  always_comb begin
    strobe_d = '0;
    if (en_i) strobe_d = W'(onehot_dec(ONEHOT_IDX_W'(idx_i)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) strobe_q <= '0;
    else        strobe_q <= strobe_d;
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/frame_strobe_seq.sv
// Column configuration sequencer: accepts one frame write, drives FrameData_o, then a one-hot FrameStrobe pulse.
// Latency: accept at T -> data at T+1, strobe at T+1+SETUP_CYCLES for STROBE_CYCLES, ready at T+SETUP+STROBE+2.
// Backpressure: cfg_ready is low for the whole sequence; writes for other columns or bad frames drop in IDLE.
// Ports: UserCLK, resetn (sync, active low), cfg_valid/cfg_ready/cfg_col/cfg_frame/cfg_data (write request),
//        FrameData_o, FrameStrobe (to tile column), busy, err_frame (sticky), err_clr.
// Optional macro FRAME_STROBE_CNT_EN adds strobe_count[15:0], a saturating count of STROBE entries.
module frame_strobe_seq
  import cfg_seq_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int COL_ID          = 0,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 1
) (
  input  logic                               UserCLK,
  input  logic                               resetn,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [COL_W-1:0]                   cfg_col,
  input  logic [$clog2(MaxFramesPerCol)-1:0] cfg_frame,
  input  logic [FrameBitsPerRow-1:0]         cfg_data,
  output logic [FrameBitsPerRow-1:0]         FrameData_o,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               err_frame,
  input  logic                               err_clr
`ifdef FRAME_STROBE_CNT_EN
  ,
  output logic [15:0]                        strobe_count
`endif
);

  localparam int FW = $clog2(MaxFramesPerCol);
  localparam logic [31:0]      MAXF_W    = 32'(MaxFramesPerCol);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);

  // Parameter range guards (frame count bounded by the shared one-hot decoder width).
  if (COL_ID < 0 || COL_ID > 31) begin : g_bad_col
    $error("frame_strobe_seq: COL_ID must be 0..31");
  end
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("frame_strobe_seq: SETUP_CYCLES must be 1..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("frame_strobe_seq: STROBE_CYCLES must be 1..15");
  end
  if (MaxFramesPerCol < 2 || MaxFramesPerCol > ONEHOT_MAX_W) begin : g_bad_frames
    $error("frame_strobe_seq: MaxFramesPerCol must be 2..256");
  end
  if (FrameBitsPerRow < 1) begin : g_bad_width
    $error("frame_strobe_seq: FrameBitsPerRow must be >= 1");
  end

  seq_state_e                 state_d, state_q;
  logic [CNT_W-1:0]           cnt_d, cnt_q;
  logic [FW-1:0]              frame_d, frame_q;
  logic [FrameBitsPerRow-1:0] data_d, data_q;
  logic                       err_d, err_q;
  logic                       rdy_en_q;   // holds cfg_ready low during reset
  logic                       accept, col_hit, bad_frame, strobe_en;

  assign accept    = cfg_valid && cfg_ready;
  assign col_hit   = accept && (cfg_col == COL_W'(COL_ID));
  assign bad_frame = col_hit && ({{(32-FW){1'b0}}, cfg_frame} >= MAXF_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    data_d  = data_q;
    // Set wins over clear when both happen in the same cycle.
    err_d   = err_q;
    if (err_clr)   err_d = 1'b0;
    if (bad_frame) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (col_hit && !bad_frame) begin
          frame_d = cfg_frame;
          data_d  = cfg_data;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) state_d = ST_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HOLD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The strobe register loads from the next state so FrameStrobe tracks STROBE exactly.
  assign strobe_en = (state_d == ST_STROBE);

  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      frame_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

  strobe_onehot_reg #(
    .W  (MaxFramesPerCol),
    .IW (FW)
  ) u_strobe (
    .clk      (UserCLK),
    .rst_n    (resetn),
    .en_i     (strobe_en),
    .idx_i    (frame_q),
    .strobe_o (FrameStrobe)
  );

  assign cfg_ready   = (state_q == ST_IDLE) && rdy_en_q;
  assign busy        = (state_q != ST_IDLE);
  assign FrameData_o = data_q;
  assign err_frame   = err_q;

`ifdef FRAME_STROBE_CNT_EN
  logic [15:0] scnt_d, scnt_q;

  always_comb begin
    scnt_d = scnt_q;
    if (state_q != ST_STROBE && state_d == ST_STROBE && scnt_q != 16'hFFFF)
      scnt_d = scnt_q + 16'd1;
    if (err_clr) scnt_d = '0;
  end

  always_ff @(posedge UserCLK) begin
    if (!resetn) scnt_q <= '0;
    else         scnt_q <= scnt_d;
  end

  assign strobe_count = scnt_q;
`endif

endmodule
